// File: rtl/alu_pipe.sv
// rtl/alu_pipe.sv - handshaked parametrised ALU stage between register-file read and writeback
// Optional iterative shift-add multiplier on opcode 6 is built when ALU_PIPE_MUL_EN is defined.
module alu_pipe #(
  parameter int WIDTH = 16,
  parameter int IMM_W = 8
) (
  input  logic             I_clk,
  input  logic             I_rst_n,
  input  logic             I_valid,
  output logic             O_ready,
  input  logic [4:0]       I_aluop,
  input  logic [WIDTH-1:0] I_dataA,
  input  logic [WIDTH-1:0] I_dataB,
  input  logic [IMM_W-1:0] I_imm,
  output logic             O_valid,
  input  logic             I_res_ready,
  output logic [WIDTH-1:0] O_dataresult,
  output logic [3:0]       O_flags,
  output logic             O_shldBranch,
  output logic             O_busy
);
  localparam int SHAMT_W = $clog2(WIDTH);

`ifdef ALU_PIPE_MUL_EN
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_DONE = 2'd1, S_MUL = 2'd2} state_t;
`else
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_DONE = 2'd1} state_t;
`endif

  state_t             state;
  logic [WIDTH-1:0]   res_q;
  logic [3:0]         flags_q;
  logic               br_q;

  logic [3:0]         opcode;
  logic               op_lsb;
  logic               accept;
  logic [WIDTH:0]     add_w, sub_w;
  logic [WIDTH-1:0]   imm_ext, alu_res;
  logic               alu_c, alu_v, alu_br, alu_def;
  logic               a_gt_b, a_lt_b;
  logic [SHAMT_W-1:0] br_idx;
  logic [3:0]         alu_flags;

  assign opcode  = I_aluop[4:1];
  assign op_lsb  = I_aluop[0];
  assign O_ready = (state == S_IDLE) || (state == S_DONE && I_res_ready);
  assign accept  = I_valid && O_ready;

  assign O_valid      = (state == S_DONE);
  assign O_dataresult = res_q;
  assign O_flags      = flags_q;
  assign O_shldBranch = br_q;

  always_comb begin
    add_w   = {1'b0, I_dataA} + {1'b0, I_dataB};
    sub_w   = {1'b0, I_dataA} - {1'b0, I_dataB};
    imm_ext = WIDTH'(I_imm);
    a_gt_b  = op_lsb ? ($signed(I_dataA) > $signed(I_dataB)) : (I_dataA > I_dataB);
    a_lt_b  = op_lsb ? ($signed(I_dataA) < $signed(I_dataB)) : (I_dataA < I_dataB);
    br_idx  = SHAMT_W'({op_lsb, I_imm[1:0]});
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    alu_br  = 1'b0;
    alu_def = 1'b1;
    case (opcode)
      4'd0: begin
        alu_res = add_w[WIDTH-1:0];
        alu_c   = add_w[WIDTH];
        alu_v   = (I_dataA[WIDTH-1] == I_dataB[WIDTH-1]) && (add_w[WIDTH-1] != I_dataA[WIDTH-1]);
      end
      4'd1: begin
        alu_res = sub_w[WIDTH-1:0];
        alu_c   = sub_w[WIDTH];
        alu_v   = (I_dataA[WIDTH-1] != I_dataB[WIDTH-1]) && (sub_w[WIDTH-1] != I_dataA[WIDTH-1]);
      end
      4'd2:  alu_res = I_dataA | I_dataB;
      4'd3:  alu_res = I_dataA & I_dataB;
      4'd4:  alu_res = I_dataA ^ I_dataB;
      4'd5:  alu_res = ~I_dataA;
      4'd8:  alu_res = op_lsb ? (imm_ext << (WIDTH - IMM_W)) : imm_ext;
      4'd9:  alu_res[4:0] = {a_lt_b, a_gt_b, ~|I_dataB, ~|I_dataA, I_dataA == I_dataB};
      4'd10: alu_res = I_dataA << I_dataB[SHAMT_W-1:0];
      4'd11: alu_res = I_dataA >> I_dataB[SHAMT_W-1:0];
      4'd12: begin
        alu_res = op_lsb ? I_dataA : imm_ext;
        alu_br  = 1'b1;
      end
      4'd13: begin
        alu_res = I_dataA;
        alu_br  = I_dataB[br_idx];
      end
      default: alu_def = 1'b0;
    endcase
    // Undefined opcodes report all-zero flags, including Z.
    alu_flags = alu_def ? {alu_v, alu_c, alu_res[WIDTH-1], ~|alu_res} : 4'b0000;
  end

`ifdef ALU_PIPE_MUL_EN
  logic [2*WIDTH-1:0] mul_acc, mul_cand, mul_sum, mul_prod;
  logic [WIDTH-1:0]   mul_plier, a_mag, b_mag;
  logic [SHAMT_W-1:0] mul_cnt;
  logic               mul_neg, mul_sgn, mul_c;

  assign O_busy = (state == S_MUL);

  always_comb begin
    a_mag    = (op_lsb && I_dataA[WIDTH-1]) ? -I_dataA : I_dataA;
    b_mag    = (op_lsb && I_dataB[WIDTH-1]) ? -I_dataB : I_dataB;
    mul_sum  = mul_acc + (mul_plier[0] ? mul_cand : '0);
    mul_prod = mul_neg ? -mul_sum : mul_sum;
    mul_c    = mul_sgn ? (mul_prod[2*WIDTH-1:WIDTH] != {WIDTH{mul_prod[WIDTH-1]}})
                       : (|mul_prod[2*WIDTH-1:WIDTH]);
  end
`else
  assign O_busy = 1'b0;
`endif

  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      state   <= S_IDLE;
      res_q   <= '0;
      flags_q <= '0;
      br_q    <= 1'b0;
`ifdef ALU_PIPE_MUL_EN
      mul_acc   <= '0;
      mul_cand  <= '0;
      mul_plier <= '0;
      mul_cnt   <= '0;
      mul_neg   <= 1'b0;
      mul_sgn   <= 1'b0;
`endif
    end else if (accept) begin
`ifdef ALU_PIPE_MUL_EN
      if (opcode == 4'd6) begin
        state     <= S_MUL;
        mul_acc   <= '0;
        mul_cand  <= {{WIDTH{1'b0}}, a_mag};
        mul_plier <= b_mag;
        mul_cnt   <= '0;
        mul_neg   <= op_lsb & (I_dataA[WIDTH-1] ^ I_dataB[WIDTH-1]);
        mul_sgn   <= op_lsb;
      end else begin
        state   <= S_DONE;
        res_q   <= alu_res;
        flags_q <= alu_flags;
        br_q    <= alu_br;
      end
`else
      state   <= S_DONE;
      res_q   <= alu_res;
      flags_q <= alu_flags;
      br_q    <= alu_br;
`endif
    end else if (state == S_DONE && I_res_ready) begin
      state <= S_IDLE;
`ifdef ALU_PIPE_MUL_EN
    end else if (state == S_MUL) begin
      // One partial product per cycle; the sign fix-up happens on the last step.
      mul_acc   <= mul_sum;
      mul_cand  <= mul_cand << 1;
      mul_plier <= mul_plier >> 1;
      mul_cnt   <= mul_cnt + SHAMT_W'(1);
      if (mul_cnt == SHAMT_W'(WIDTH - 1)) begin
        state   <= S_DONE;
        res_q   <= mul_prod[WIDTH-1:0];
        flags_q <= {mul_c, mul_c, mul_prod[WIDTH-1], ~|mul_prod[WIDTH-1:0]};
        br_q    <= 1'b0;
      end
`endif
    end
  end
endmodule

// File: tb/tb_alu_pipe.sv
// tb/tb_alu_pipe.sv - table-driven bench for alu_pipe plus stall, multiplier and reset sequences
module tb_alu_pipe;
  localparam int W  = 16;
  localparam int IW = 8;

  logic          clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, res_ready = 1'b0;
  logic [4:0]    aluop = '0;
  logic [W-1:0]  a = '0, b = '0;
  logic [IW-1:0] imm = '0;
  logic          ready, valid, br, busy;
  logic [W-1:0]  res;
  logic [3:0]    flags;

  int n_vec = 0;
  int n_bad = 0;

  alu_pipe #(.WIDTH(W), .IMM_W(IW)) dut (
    .I_clk(clk), .I_rst_n(rst_n), .I_valid(in_valid), .O_ready(ready),
    .I_aluop(aluop), .I_dataA(a), .I_dataB(b), .I_imm(imm),
    .O_valid(valid), .I_res_ready(res_ready), .O_dataresult(res),
    .O_flags(flags), .O_shldBranch(br), .O_busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]    op;
    logic [W-1:0]  va, vb;
    logic [IW-1:0] vimm;
    logic [W-1:0]  eres;
    logic [3:0]    eflags;
    logic          ebr;
  } vec_t;

  vec_t vecs[22];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_zero_outs(input string nm);
    chk({nm, "_valid"}, 32'(valid), 32'd0);
    chk({nm, "_res"},   32'(res),   32'd0);
    chk({nm, "_flags"}, 32'(flags), 32'd0);
    chk({nm, "_br"},    32'(br),    32'd0);
    chk({nm, "_busy"},  32'(busy),  32'd0);
    chk({nm, "_ready"}, 32'(ready), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int cyc;
    int seen;
    // {aluop, A, B, imm, result, {V,C,N,Z}, branch}
    vecs[0]  = '{5'b00000, 16'hFFFF, 16'h0001, 8'h00, 16'h0000, 4'b0101, 1'b0};
    vecs[1]  = '{5'b00011, 16'h8000, 16'h0001, 8'h00, 16'h7FFF, 4'b1000, 1'b0};
    vecs[2]  = '{5'b00010, 16'h0001, 16'h0002, 8'h00, 16'hFFFF, 4'b0110, 1'b0};
    vecs[3]  = '{5'b00001, 16'h7FFF, 16'h0001, 8'h00, 16'h8000, 4'b1010, 1'b0};
    vecs[4]  = '{5'b00100, 16'h00F0, 16'h0F00, 8'h00, 16'h0FF0, 4'b0000, 1'b0};
    vecs[5]  = '{5'b00110, 16'hF0F0, 16'hFF00, 8'h00, 16'hF000, 4'b0010, 1'b0};
    vecs[6]  = '{5'b01000, 16'hAAAA, 16'hAAAA, 8'h00, 16'h0000, 4'b0001, 1'b0};
    vecs[7]  = '{5'b01010, 16'h0000, 16'h1234, 8'h00, 16'hFFFF, 4'b0010, 1'b0};
    vecs[8]  = '{5'b10001, 16'h0000, 16'h0000, 8'hA5, 16'hA500, 4'b0010, 1'b0};
    vecs[9]  = '{5'b10000, 16'h0000, 16'h0000, 8'hA5, 16'h00A5, 4'b0000, 1'b0};
    vecs[10] = '{5'b10011, 16'hFFFF, 16'h0001, 8'h00, 16'h0010, 4'b0000, 1'b0};
    vecs[11] = '{5'b10010, 16'hFFFF, 16'h0001, 8'h00, 16'h0008, 4'b0000, 1'b0};
    vecs[12] = '{5'b10010, 16'h0000, 16'h0000, 8'h00, 16'h0007, 4'b0000, 1'b0};
    vecs[13] = '{5'b10100, 16'h0001, 16'h0013, 8'h00, 16'h0008, 4'b0000, 1'b0};
    vecs[14] = '{5'b10110, 16'h8000, 16'h000F, 8'h00, 16'h0001, 4'b0000, 1'b0};
    vecs[15] = '{5'b11000, 16'h1234, 16'h0000, 8'h3C, 16'h003C, 4'b0000, 1'b1};
    vecs[16] = '{5'b11001, 16'h8000, 16'h0000, 8'h3C, 16'h8000, 4'b0010, 1'b1};
    vecs[17] = '{5'b11011, 16'h1234, 16'h0020, 8'h01, 16'h1234, 4'b0000, 1'b1};
    vecs[18] = '{5'b11011, 16'h1234, 16'h0020, 8'h00, 16'h1234, 4'b0000, 1'b0};
    vecs[19] = '{5'b11010, 16'h0000, 16'h0002, 8'h01, 16'h0000, 4'b0001, 1'b1};
    vecs[20] = '{5'b01110, 16'hFFFF, 16'hFFFF, 8'hFF, 16'h0000, 4'b0000, 1'b0};
    vecs[21] = '{5'b11100, 16'h1234, 16'h5678, 8'h12, 16'h0000, 4'b0000, 1'b0};

    #12;
    chk_zero_outs("reset");
    rst_n = 1'b1;
    step();
    chk("idle_ready", 32'(ready), 32'd1);

    // Back-to-back issue: every vector is accepted while the previous result drains.
    res_ready = 1'b1;
    for (int i = 0; i < 22; i++) begin
      aluop = vecs[i].op; a = vecs[i].va; b = vecs[i].vb; imm = vecs[i].vimm;
      in_valid = 1'b1;
      step();
      chk($sformatf("vec%0d_valid", i), 32'(valid), 32'd1);
      chk($sformatf("vec%0d_res", i),   32'(res),   32'(vecs[i].eres));
      chk($sformatf("vec%0d_flags", i), 32'(flags), 32'(vecs[i].eflags));
      chk($sformatf("vec%0d_br", i),    32'(br),    32'(vecs[i].ebr));
    end
    in_valid = 1'b0;
    step();
    chk("drain_valid", 32'(valid), 32'd0);

    // Consumer stall with operand changes after acceptance.
    aluop = 5'b00011; a = 16'h8000; b = 16'h0001; in_valid = 1'b1; res_ready = 1'b0;
    step();
    in_valid = 1'b0; a = 16'h1234; b = 16'h4321;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("stall%0d_valid", k), 32'(valid), 32'd1);
      chk($sformatf("stall%0d_res", k),   32'(res),   32'h7FFF);
      chk($sformatf("stall%0d_flags", k), 32'(flags), 32'h8);
      chk($sformatf("stall%0d_ready", k), 32'(ready), 32'd0);
      step();
    end
    res_ready = 1'b1;
    #1;
    chk("stall_release_ready", 32'(ready), 32'd1);
    step();
    chk("stall_release_valid", 32'(valid), 32'd0);

`ifdef ALU_PIPE_MUL_EN
    aluop = 5'b01100; a = 16'h0100; b = 16'h0100; in_valid = 1'b1; res_ready = 1'b0;
    step();
    chk("mul_accept_ready", 32'(ready), 32'd0);
    aluop = 5'b00000; a = 16'h0001; b = 16'h0001;
    cyc = 0;
    while (busy && cyc < 40) begin
      cyc++;
      in_valid = cyc[0];
      step();
    end
    in_valid = 1'b0;
    chk("mul_busy_cycles", 32'(cyc),   32'd16);
    chk("mul_valid",       32'(valid), 32'd1);
    chk("mul_res",         32'(res),   32'h0000);
    chk("mul_flags",       32'(flags), 32'hD);
    res_ready = 1'b1;
    step();
    chk("mul_drain_valid", 32'(valid), 32'd0);

    aluop = 5'b01101; a = 16'hFFFE; b = 16'h0003; in_valid = 1'b1; res_ready = 1'b0;
    step();
    in_valid = 1'b0;
    cyc = 0;
    while (!valid && cyc < 40) begin
      cyc++;
      step();
    end
    chk("smul_latency", 32'(cyc),   32'd16);
    chk("smul_res",     32'(res),   32'hFFFA);
    chk("smul_flags",   32'(flags), 32'h2);
    res_ready = 1'b1;
    step();

    // Abort a multiply part-way through.
    aluop = 5'b01100; a = 16'h0100; b = 16'h0100; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    for (int k = 0; k < 4; k++) step();
    chk("abort_busy_before", 32'(busy), 32'd1);
`else
    aluop = 5'b01100; a = 16'hFFFF; b = 16'hFFFF; in_valid = 1'b1; res_ready = 1'b0;
    step();
    in_valid = 1'b0;
    chk("op6_valid", 32'(valid), 32'd1);
    chk("op6_res",   32'(res),   32'd0);
    chk("op6_flags", 32'(flags), 32'd0);
    chk("op6_busy",  32'(busy),  32'd0);
    res_ready = 1'b1;
    step();

    aluop = 5'b00000; a = 16'h0001; b = 16'h0001; in_valid = 1'b1; res_ready = 1'b0;
    step();
    in_valid = 1'b0;
    chk("abort_held_res", 32'(res), 32'h0002);
`endif
    rst_n = 1'b0;
    #1;
    chk_zero_outs("abort");
    step();
    rst_n = 1'b1;
    res_ready = 1'b1;
    seen = 0;
    for (int k = 0; k < 24; k++) begin
      step();
      if (valid) seen++;
    end
    chk("abort_no_valid", 32'(seen), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
